// File: rtl/dmem_block_memory_if.sv
// Request/response bundle between the data-cache miss FSM (master) and the
// block memory (slave).
interface dmem_block_memory_if #(
    parameter int ADDR_W     = 8,
    parameter int BLOCK_BITS = 256
);
    logic                  ren;
    logic                  wen;
    logic [ADDR_W-1:0]     addr;
    logic [BLOCK_BITS-1:0] din;
    logic [BLOCK_BITS-1:0] dout;
    logic                  readReady;
    logic                  writeDone;

    modport master (
        output ren, wen, addr, din,
        input  dout, readReady, writeDone
    );

    modport slave (
        input  ren, wen, addr, din,
        output dout, readReady, writeDone
    );
endinterface

// File: rtl/dmem_block_memory.sv
// Block-granular data memory with fixed read/write latency and a one-cycle
// registered completion pulse; dout holds the last read block.
module dmem_block_memory #(
    parameter int ADDR_W     = 8,
    parameter int BLOCK_BITS = 256,
    parameter int READ_LAT   = 4,
    parameter int WRITE_LAT  = 4
) (
    input  logic               clock,
    input  logic               reset,
    dmem_block_memory_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] READ_CNT  = 4'(READ_LAT - 1);
    localparam logic [3:0] WRITE_CNT = 4'(WRITE_LAT - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [BLOCK_BITS-1:0] din_q;
    logic [BLOCK_BITS-1:0] dout_q;
    logic                  read_ready_q;
    logic                  write_done_q;
    logic                  commit;

    logic [BLOCK_BITS-1:0] mem [2**ADDR_W];

    assign commit        = (state == WRITE) && (cnt == 4'd0);
    assign bus.dout      = dout_q;
    assign bus.readReady = read_ready_q;
    assign bus.writeDone = write_done_q;

    // NOTE: the array has no reset; an aborted write is never committed
    // because reset forces the FSM out of WRITE before commit can assert.
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[addr_q] <= din_q;
        end
    end

    // Write wins over a simultaneous read; the read must be re-presented.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr_q       <= '0;
            din_q        <= '0;
            dout_q       <= '0;
            read_ready_q <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            read_ready_q <= 1'b0;
            write_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wen) begin
                        state  <= WRITE;
                        cnt    <= WRITE_CNT;
                        addr_q <= bus.addr;
                        din_q  <= bus.din;
                    end else if (bus.ren) begin
                        state  <= READ;
                        cnt    <= READ_CNT;
                        addr_q <= bus.addr;
                    end
                end
                READ: begin
                    if (cnt == 4'd0) begin
                        state        <= DONE;
                        dout_q       <= mem[addr_q];
                        read_ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (cnt == 4'd0) begin
                        state        <= DONE;
                        write_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_block_memory.sv
// Scoreboard bench for dmem_block_memory: three instances cover READ_LAT of
// 4, 1 and 15; expected completions are queued at issue and popped on pulse.
module tb_dmem_block_memory;
    localparam int AW = 8;
    localparam int BB = 256;

    typedef struct {
        int              d;
        bit              rd;
        logic [BB-1:0]   data;
        int              due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    int total = 0;
    int bad   = 0;
    int rlat [3] = '{4, 1, 15};

    logic          ren_v  [3];
    logic          wen_v  [3];
    logic [AW-1:0] addr_v [3];
    logic [BB-1:0] din_v  [3];
    logic [BB-1:0] dout_v [3];
    logic          rdy_v  [3];
    logic          done_v [3];

    exp_t          exp_q [$];
    logic [BB-1:0] shadow [int];

    dmem_block_memory_if #(.ADDR_W(AW), .BLOCK_BITS(BB)) if0 ();
    dmem_block_memory_if #(.ADDR_W(AW), .BLOCK_BITS(BB)) if1 ();
    dmem_block_memory_if #(.ADDR_W(AW), .BLOCK_BITS(BB)) if2 ();

    assign if0.ren = ren_v[0];  assign if0.wen = wen_v[0];
    assign if0.addr = addr_v[0]; assign if0.din = din_v[0];
    assign dout_v[0] = if0.dout; assign rdy_v[0] = if0.readReady; assign done_v[0] = if0.writeDone;
    assign if1.ren = ren_v[1];  assign if1.wen = wen_v[1];
    assign if1.addr = addr_v[1]; assign if1.din = din_v[1];
    assign dout_v[1] = if1.dout; assign rdy_v[1] = if1.readReady; assign done_v[1] = if1.writeDone;
    assign if2.ren = ren_v[2];  assign if2.wen = wen_v[2];
    assign if2.addr = addr_v[2]; assign if2.din = din_v[2];
    assign dout_v[2] = if2.dout; assign rdy_v[2] = if2.readReady; assign done_v[2] = if2.writeDone;

    dmem_block_memory #(.ADDR_W(AW), .BLOCK_BITS(BB), .READ_LAT(4), .WRITE_LAT(4))
        u0 (.clock(clock), .reset(reset), .bus(if0));
    dmem_block_memory #(.ADDR_W(AW), .BLOCK_BITS(BB), .READ_LAT(1), .WRITE_LAT(4))
        u1 (.clock(clock), .reset(reset), .bus(if1));
    dmem_block_memory #(.ADDR_W(AW), .BLOCK_BITS(BB), .READ_LAT(15), .WRITE_LAT(4))
        u2 (.clock(clock), .reset(reset), .bus(if2));

    // Drive a request at a negedge and queue its expected completion edge.
    task automatic start(input int d, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BB-1:0] data, input int acc);
        exp_t e;
        ren_v[d]  = rd;
        wen_v[d]  = wr;
        addr_v[d] = a;
        din_v[d]  = data;
        e.d   = d;
        e.rd  = !wr;
        e.due = acc + (wr ? 4 : rlat[d]);
        if (wr) begin
            shadow[d * 256 + int'(a)] = data;
            e.data = data;
        end else begin
            e.data = shadow.exists(d * 256 + int'(a)) ? shadow[d * 256 + int'(a)] : 'x;
        end
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a completion pulse, then drop the request.
    task automatic wait_done(input int d, input int budget, output int seen,
                             output bit saw_rd, output bit saw_wr);
        seen = -1; saw_rd = 1'b0; saw_wr = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (rdy_v[d] === 1'b1)  saw_rd = 1'b1;
            if (done_v[d] === 1'b1) saw_wr = 1'b1;
            if (saw_rd || saw_wr) begin
                seen = edge_n;
                break;
            end
        end
        ren_v[d] = 1'b0;
        wen_v[d] = 1'b0;
    endtask

    task automatic test_reset;
        int pulses, seen;
        bit sr, sw;
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            ren_v[d] = 1'b0; wen_v[d] = 1'b0; addr_v[d] = '0; din_v[d] = '0;
        end
        repeat (2) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({rdy_v[d], done_v[d], dout_v[d]} !== {2'b00, {BB{1'b0}}}) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b done=%b dout=%h want 0 0 0",
                         d, rdy_v[d], done_v[d], dout_v[d]);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        start(0, 1'b1, 1'b0, 8'h20, '0, edge_n + 1);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ren_v[0] = 1'b0;
        #1;
        total++;
        if ({rdy_v[0], dout_v[0]} !== {1'b0, {BB{1'b0}}}) begin
            bad++;
            $display("FAIL reset_mid_read: got rdy=%b dout=%h want 0 0", rdy_v[0], dout_v[0]);
        end
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            if (rdy_v[0] === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL reset_no_pulse: got %0d pulses want 0", pulses);
        end
        start(0, 1'b0, 1'b1, 8'h20, {8{32'h0BADF00D}}, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due) begin
            bad++;
            $display("FAIL reset_then_idle: got edge %0d want %0d", seen, e.due);
        end
        @(negedge clock);
    endtask

    task automatic test_write_read;
        int seen;
        bit sr, sw;
        exp_t e;
        start(0, 1'b0, 1'b1, 8'h05, {8{32'hDEADBEEF}}, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due || sw !== 1'b1 || sr !== 1'b0) begin
            bad++;
            $display("FAIL wr_done_edge: got edge %0d rd=%b wr=%b want edge %0d rd=0 wr=1",
                     seen, sr, sw, e.due);
        end
        @(negedge clock);
        total++;
        if (done_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL wr_done_width: got %b want 0", done_v[0]);
        end
        start(0, 1'b1, 1'b0, 8'h05, '0, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due || sr !== 1'b1 || sw !== 1'b0) begin
            bad++;
            $display("FAIL rd_ready_edge: got edge %0d rd=%b wr=%b want edge %0d rd=1 wr=0",
                     seen, sr, sw, e.due);
        end
        total++;
        if (dout_v[0] !== e.data) begin
            bad++;
            $display("FAIL rd_data: got %h want %h", dout_v[0], e.data);
        end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clock);
            total++;
            if (dout_v[0] !== e.data || rdy_v[0] !== 1'b0) begin
                bad++;
                $display("FAIL rd_hold_%0d: got rdy=%b dout=%h want rdy=0 dout=%h",
                         i, rdy_v[0], dout_v[0], e.data);
            end
        end
    endtask

    task automatic test_abort_write;
        int seen;
        bit sr, sw;
        exp_t e;
        logic [BB-1:0] keep;
        keep = {8{32'h13572468}};
        start(0, 1'b0, 1'b1, 8'h30, keep, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        void'(exp_q.pop_front());
        @(negedge clock);
        start(0, 1'b0, 1'b1, 8'h30, {8{32'hFFFF0000}}, edge_n + 1);
        void'(exp_q.pop_back());
        shadow[8'h30] = keep;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wen_v[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start(0, 1'b1, 1'b0, 8'h30, '0, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due || dout_v[0] !== e.data) begin
            bad++;
            $display("FAIL abort_write: got edge %0d dout=%h want edge %0d dout=%h",
                     seen, dout_v[0], e.due, e.data);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int seen, m;
        bit sr, sw;
        exp_t e;
        start(0, 1'b0, 1'b1, 8'h06, {4{64'hA5A5_0000_1234_FFFF}}, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        m = seen;
        total++;
        if (seen !== e.due) begin
            bad++;
            $display("FAIL wb_done_edge: got edge %0d want %0d", seen, e.due);
        end
        start(0, 1'b1, 1'b0, 8'h06, '0, m + 2);
        @(negedge clock);
        total++;
        if (rdy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL wb_done_ignores: got rdy=%b done=%b want 0 0", rdy_v[0], done_v[0]);
        end
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due || sr !== 1'b1) begin
            bad++;
            $display("FAIL refill_edge: got edge %0d rd=%b want edge %0d rd=1", seen, sr, e.due);
        end
        total++;
        if (dout_v[0] !== e.data) begin
            bad++;
            $display("FAIL refill_data: got %h want %h", dout_v[0], e.data);
        end
        @(negedge clock);
    endtask

    task automatic test_simultaneous;
        int seen;
        bit sr, sw;
        exp_t e;
        start(0, 1'b1, 1'b1, 8'h10, '1, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due || sw !== 1'b1 || sr !== 1'b0) begin
            bad++;
            $display("FAIL simul_write_wins: got edge %0d rd=%b wr=%b want edge %0d rd=0 wr=1",
                     seen, sr, sw, e.due);
        end
        @(negedge clock);
        start(0, 1'b1, 1'b0, 8'h10, '0, edge_n + 1);
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due || dout_v[0] !== e.data) begin
            bad++;
            $display("FAIL simul_readback: got edge %0d dout=%h want edge %0d dout=%h",
                     seen, dout_v[0], e.due, e.data);
        end
        @(negedge clock);
    endtask

    task automatic test_input_stability;
        int seen;
        bit sr, sw;
        exp_t e;
        for (int i = 1; i <= 2; i++) begin
            start(0, 1'b0, 1'b1, AW'(i), {8{$urandom}}, edge_n + 1);
            wait_done(0, 20, seen, sr, sw);
            void'(exp_q.pop_front());
            @(negedge clock);
        end
        start(0, 1'b1, 1'b0, 8'h01, '0, edge_n + 1);
        @(negedge clock);
        addr_v[0] = 8'h02;
        din_v[0]  = {8{$urandom}};
        wait_done(0, 20, seen, sr, sw);
        e = exp_q.pop_front();
        total++;
        if (seen !== e.due || dout_v[0] !== e.data) begin
            bad++;
            $display("FAIL addr_latched: got edge %0d dout=%h want edge %0d dout=%h",
                     seen, dout_v[0], e.due, e.data);
        end
        @(negedge clock);
    endtask

    task automatic test_latency_sweep;
        int seen, pulses;
        bit sr, sw;
        exp_t e;
        for (int d = 1; d <= 2; d++) begin
            start(d, 1'b0, 1'b1, AW'(8'h40 + d), {8{$urandom}}, edge_n + 1);
            wait_done(d, 20, seen, sr, sw);
            void'(exp_q.pop_front());
            @(negedge clock);
            start(d, 1'b1, 1'b0, AW'(8'h40 + d), '0, edge_n + 1);
            wait_done(d, 30, seen, sr, sw);
            e = exp_q.pop_front();
            total++;
            if (seen !== e.due || dout_v[d] !== e.data) begin
                bad++;
                $display("FAIL lat_sweep_dut%0d: got edge %0d dout=%h want edge %0d dout=%h",
                         d, seen, dout_v[d], e.due, e.data);
            end
            pulses = 0;
            repeat (20) begin
                @(negedge clock);
                if (rdy_v[d] === 1'b1) pulses++;
            end
            total++;
            if (pulses !== 0) begin
                bad++;
                $display("FAIL lat_single_pulse_dut%0d: got %0d extra pulses want 0", d, pulses);
            end
        end
    endtask

    task automatic test_random_mix;
        int seen;
        bit sr, sw, wr;
        exp_t e;
        logic [AW-1:0] pool [5];
        logic [AW-1:0] a;
        pool = '{8'h01, 8'h02, 8'h05, 8'h06, 8'h10};
        for (int i = 0; i < 8; i++) begin
            a  = pool[$urandom_range(0, 4)];
            wr = ($urandom_range(0, 1) == 1);
            start(0, !wr, wr, a, {8{$urandom}}, edge_n + 1);
            wait_done(0, 20, seen, sr, sw);
            e = exp_q.pop_front();
            total++;
            if (seen !== e.due || sr !== e.rd || sw !== !e.rd || (e.rd && dout_v[0] !== e.data)) begin
                bad++;
                $display("FAIL mix_%0d: got edge %0d rd=%b dout=%h want edge %0d rd=%b dout=%h",
                         i, seen, sr, dout_v[0], e.due, e.rd, e.data);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_abort_write;
        test_back_to_back;
        test_simultaneous;
        test_input_stability;
        test_latency_sweep;
        test_random_mix;
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_block_memory.md
# dmem_block_memory

Block-granular data main memory with fixed, parameterised access latency that sits directly downstream of the data-cache controller. It serves the miss FSM's writeback (`memWen`) and refill (`memRen`) requests. It returns a one-cycle `readReady`/`writeDone` completion pulse, and `dout` holds the read block stable afterwards so the cache can be filled in the following cycle.

## Interface
Parameters:
- `ADDR_W`, 8: block-address width; the array holds 2^ADDR_W blocks.
- `BLOCK_BITS`, 256: block width in bits; must match the cache block size.
- `READ_LAT`, 4: cycles from read acceptance to `readReady`; legal range 1..15.
- `WRITE_LAT`, 4: cycles from write acceptance to `writeDone`; legal range 1..15.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ren` in 1: read request, level, held by the requester until `readReady`.
- `wen` in 1: write request, level, held by the requester until `writeDone`.
- `addr` in ADDR_W: block address.
- `din` in BLOCK_BITS: write data (victim block).
- `dout` out BLOCK_BITS: read data; registered, held until the next read completes.
- `readReady` out 1: one-cycle read-completion pulse; registered.
- `writeDone` out 1: one-cycle write-completion pulse; registered.

## Operation
- Storage: array of 2^ADDR_W × BLOCK_BITS. Contents are not affected by reset and are undefined until written.
- FSM states:
  - IDLE: accepts requests.
  - READ: counting down read latency.
  - WRITE: counting down write latency.
  - DONE: single cycle, response pulse high.
- Transitions:
  - IDLE → WRITE at an edge with `wen`=1. Write has priority when `ren` and `wen` are both 1; the read is not accepted and must be re-presented.
  - IDLE → READ at an edge with `ren`=1 and `wen`=0.
  - IDLE → IDLE otherwise.
  - READ/WRITE → DONE at the edge where the latency counter is 0.
  - READ/WRITE → same state otherwise, with counter decrement.
  - DONE → IDLE unconditionally.
- At acceptance:
  - `addr` is latched, and `din` too for writes.
  - The counter is loaded with LAT−1 (4-bit, no wrap: it stops at 0).
  - Input changes after acceptance are ignored.
- On READ→DONE edge: `dout` ← array[latched addr]; `readReady` ← 1.
- On WRITE→DONE edge: array[latched addr] ← latched din; `writeDone` ← 1.
- In DONE: `ren`/`wen` are ignored. A request still high on the DONE→IDLE edge is not accepted there. It is accepted at the first IDLE-state edge, which supports a writeback immediately followed by a refill.
- `readReady` and `writeDone` are never high together and are high only in DONE.
- Read-after-write to the same address returns the newly written block.

## Timing
- Reset, asynchronous, any state:
  - state = IDLE, counter = 0.
  - `readReady` = 0, `writeDone` = 0, `dout` = 0.
  - A write in progress is aborted and not committed to the array.
- Read latency: request accepted at edge k → `readReady` high during cycle [k+READ_LAT, k+READ_LAT+1).
- Write latency: request accepted at edge k → array updated and `writeDone` high at edge k+WRITE_LAT.
- `dout` is valid from edge k+READ_LAT and stable through at least the following cycle. It is stable until the next read's DONE edge, which covers the requester's fill cycle.
- Minimum turnaround: completion at edge m → next acceptance no earlier than edge m+2, which is the first edge where the FSM is in IDLE.
- Writeback + refill sequence:
  - write accepted at edge 0 → `writeDone` at edge WRITE_LAT;
  - read accepted at edge WRITE_LAT+2 → `readReady` at edge WRITE_LAT+2+READ_LAT.
- `readReady`/`writeDone` are pure registers with no combinational path from inputs.

## Test plan
- Reset: drive `reset`=0 mid-READ (counter=2), then release → state IDLE, `readReady`=0, `dout`=0, and no `readReady` pulse ever follows.
- Write then read, LAT=4: write `addr`=0x05, `din`={8{32'hDEADBEEF}} accepted at edge 0 → `writeDone` high exactly at edge 4 for one cycle. Read 0x05 accepted at edge 6 → `readReady` at edge 10 with `dout`=={8{32'hDEADBEEF}}, held unchanged at edges 11 and 12.
- Writeback + refill: `wen` held until `writeDone`, then `ren` raised the same cycle for 0x06 → `ren` ignored in DONE; read accepted at edge WRITE_LAT+2; `readReady` at edge WRITE_LAT+2+READ_LAT.
- Simultaneous `ren`=`wen`=1 with `addr`=0x10, `din`=all-ones → write performed, `writeDone` pulses, `readReady` stays 0; a later read of 0x10 returns all-ones.
- Input stability: change `addr` from 0x01 to 0x02 one cycle after read acceptance → `dout` returns the block at 0x01.
- Latency sweep: READ_LAT=1 → `readReady` at edge k+1; READ_LAT=15 → `readReady` at edge k+15. Exactly one pulse per request in both cases.
